elevator_scan: RTL and testbench

ELEVATOR_SCAN -- requirements
Module: elevator_scan

---
 rtl/elevator_scan.sv | 110 +++++++++++
 tb/tb_elevator_scan.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan.sv
// Single-car SCAN elevator controller: latches floor calls, sweeps in one direction while calls remain ahead.
// Latency: call-to-pending 1 edge, pending-to-motion 1 edge; all outputs are registered Moore decodes of state.
// Backpressure: none; door_hold or a call to the open floor keeps the door open by reloading its timer.
module elevator_scan #(
    parameter int NUM_FLOORS  = 4,
    parameter int FLOOR_W     = 2,
    parameter int DOOR_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  at_floor,
    input  logic                  door_hold,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);
    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]      T_LOAD = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   NF     = (FLOOR_W + 1)'(NUM_FLOORS);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t                  state, nxt, scan;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    dir_pref;
    logic                    floor_ok, above, below, here_call, arrive;
    logic [NUM_FLOORS-1:0]   cur_oh, clr;

    always_comb begin
        floor_ok = at_floor && ({1'b0, cur_floor} < NF);
        cur_oh   = '0;
        above    = 1'b0;
        below    = 1'b0;
        // Without a valid floor there is no reference point, so no direction is derived.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_ok && int'(cur_floor) == i) cur_oh[i] = 1'b1;
            if (floor_ok && i > int'(cur_floor))  above = above | pending[i];
            if (floor_ok && i < int'(cur_floor))  below = below | pending[i];
        end
        here_call = |(pending & cur_oh);
        arrive    = |(req & cur_oh);

        if (above && below) scan = dir_pref ? MOVE_UP : MOVE_DOWN;
        else if (above)     scan = MOVE_UP;
        else if (below)     scan = MOVE_DOWN;
        else                scan = IDLE;

        nxt = state;
        case (state)
            IDLE: nxt = here_call ? DOOR : scan;
            MOVE_UP: begin
                if (floor_ok) begin
                    if (here_call)  nxt = DOOR;
                    else if (above) nxt = MOVE_UP;
                    else if (below) nxt = MOVE_DOWN;
                    else            nxt = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (floor_ok) begin
                    if (here_call)  nxt = DOOR;
                    else if (below) nxt = MOVE_DOWN;
                    else if (above) nxt = MOVE_UP;
                    else            nxt = IDLE;
                end
            end
            DOOR: begin
                if (!door_hold && !arrive && timer == '0) nxt = scan;
            end
            default: nxt = IDLE;
        endcase

        // Calls to the open floor are absorbed rather than latched.
        clr = (state == DOOR || nxt == DOOR) ? cur_oh : '0;

        timer_nxt = timer;
        if (state != DOOR && nxt == DOOR)   timer_nxt = T_LOAD;
        else if (state == DOOR) begin
            if (door_hold || arrive)        timer_nxt = T_LOAD;
            else if (timer != '0)           timer_nxt = timer - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            timer     <= '0;
            dir_pref  <= 1'b1;
            dir_up    <= 1'b0;
            dir_down  <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            pending   <= (pending | req) & ~clr;
            timer     <= timer_nxt;
            if (nxt == MOVE_UP)        dir_pref <= 1'b1;
            else if (nxt == MOVE_DOWN) dir_pref <= 1'b0;
            dir_up    <= (nxt == MOVE_UP);
            dir_down  <= (nxt == MOVE_DOWN);
            door_open <= (nxt == DOOR);
            busy      <= (nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_elevator_scan.sv
// Directed-vector bench for elevator_scan (4 floors, 5-cycle door) with hand-computed expectations.
module tb_elevator_scan;
    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] cur_floor;
    logic       at_floor;
    logic       door_hold;
    logic       dir_up, dir_down, door_open, busy;
    logic [3:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    elevator_scan #(.NUM_FLOORS(4), .FLOOR_W(2), .DOOR_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .req(req), .cur_floor(cur_floor), .at_floor(at_floor),
        .door_hold(door_hold), .dir_up(dir_up), .dir_down(dir_down), .door_open(door_open),
        .pending(pending), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        chk("dir_excl", int'(dir_up & dir_down), 0);
    endtask

    // Counts cycles door_open stays high, starting with the current (already open) cycle.
    task automatic door_len(input string tag, input int exp);
        int n = 0;
        while (door_open && n < 50) begin
            n++;
            tick();
        end
        chk(tag, n, exp);
    endtask

    task automatic goto_floor(input logic [1:0] f);
        cur_floor = f;
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1; req = '0; cur_floor = 2'd0; at_floor = 1'b1; door_hold = 1'b0;
        #12;
        chk("rst_dir_up", int'(dir_up), 0);
        chk("rst_dir_down", int'(dir_down), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pending", int'(pending), 0);
        rst = 1'b0;

        // Single call to floor 2 from floor 0
        req = 4'b0100; tick(); req = '0;
        chk("a_pend_e1", int'(pending), 'h4);
        chk("a_up_e1", int'(dir_up), 0);
        tick();
        chk("a_up_e2", int'(dir_up), 1);
        chk("a_busy_e2", int'(busy), 1);
        at_floor = 1'b0; tick();
        at_floor = 1'b1; goto_floor(2'd1);
        chk("a_pass1_up", int'(dir_up), 1);
        chk("a_pass1_door", int'(door_open), 0);
        goto_floor(2'd2);
        chk("a_door", int'(door_open), 1);
        chk("a_up_off", int'(dir_up), 0);
        chk("a_pend_clr", int'(pending), 0);
        door_len("a_door_len", 5);
        chk("a_idle", int'(busy), 0);

        // Moving up with call at 3, calls at 0 and 1 added en route: service 1,3,0
        cur_floor = 2'd0;
        req = 4'b1000; tick(); req = '0; tick();
        chk("b_up", int'(dir_up), 1);
        at_floor = 1'b0; req = 4'b0011; tick(); req = '0;
        chk("b_pend", int'(pending), 'hb);
        at_floor = 1'b1; goto_floor(2'd1);
        chk("b_door1", int'(door_open), 1);
        chk("b_pend1", int'(pending), 'h9);
        door_len("b_len1", 5);
        chk("b_up_again", int'(dir_up), 1);
        goto_floor(2'd2);
        chk("b_pass2", int'(door_open), 0);
        goto_floor(2'd3);
        chk("b_door3", int'(door_open), 1);
        chk("b_pend3", int'(pending), 'h1);
        door_len("b_len3", 5);
        chk("b_down", int'(dir_down), 1);
        goto_floor(2'd2);
        goto_floor(2'd1);
        chk("b_pass1_down", int'(dir_down), 1);
        goto_floor(2'd0);
        chk("b_door0", int'(door_open), 1);
        chk("b_pend0", int'(pending), 0);
        door_len("b_len0", 5);
        chk("b_idle", int'(busy), 0);

        // Idle at floor 1, preference down, calls at 0 and 3
        cur_floor = 2'd1;
        req = 4'b1001; tick(); req = '0;
        chk("c_pend", int'(pending), 'h9);
        tick();
        chk("c_down_first", int'(dir_down), 1);
        chk("c_not_up", int'(dir_up), 0);
        goto_floor(2'd0);
        chk("c_door0", int'(door_open), 1);
        chk("c_pend0", int'(pending), 'h8);
        door_len("c_len0", 5);
        chk("c_up", int'(dir_up), 1);
        goto_floor(2'd1);
        goto_floor(2'd2);
        goto_floor(2'd3);
        chk("c_door3", int'(door_open), 1);
        chk("c_pend3", int'(pending), 0);
        door_len("c_len3", 5);

        // Door at floor 2 with hold in cycles 2..4
        cur_floor = 2'd2;
        req = 4'b0100; tick(); req = '0; tick();
        chk("d_door", int'(door_open), 1);
        n = 1;
        for (int c = 2; c <= 20; c++) begin
            tick();
            door_hold = (c <= 4);
            if (door_open) n++;
        end
        door_hold = 1'b0;
        chk("d_hold_len", n, 9);
        chk("d_hold_pend", int'(pending), 0);

        // Call to the open floor reloads the timer and is not latched
        req = 4'b0100; tick(); req = '0; tick();
        chk("d2_door", int'(door_open), 1);
        n = 1;
        for (int c = 2; c <= 20; c++) begin
            tick();
            req = (c == 3) ? 4'b0100 : 4'b0000;
            if (c == 4) chk("d2_pend_absorb", int'(pending), 0);
            if (door_open) n++;
        end
        req = '0;
        chk("d2_reload_len", n, 8);
        chk("d2_idle", int'(busy), 0);

        // at_floor low over a pending floor must not stop the car
        cur_floor = 2'd0;
        req = 4'b1000; tick(); req = '0; tick();
        cur_floor = 2'd1; at_floor = 1'b0; req = 4'b0010; tick(); req = '0;
        chk("e_pend", int'(pending), 'ha);
        tick();
        chk("e_no_stop", int'(door_open), 0);
        chk("e_still_up", int'(dir_up), 1);
        chk("e_pend_kept", int'(pending), 'ha);
        at_floor = 1'b1; goto_floor(2'd3);
        chk("e_door3", int'(door_open), 1);
        chk("e_pend3", int'(pending), 'h2);
        door_len("e_len3", 5);
        chk("e_down", int'(dir_down), 1);
        goto_floor(2'd2);
        goto_floor(2'd1);
        chk("e_door1", int'(door_open), 1);
        door_len("e_len1", 5);

        // Top floor reached in MOVE_UP with nothing above: motion up must stop
        req = 4'b0100; tick(); req = '0; tick();
        chk("f_up", int'(dir_up), 1);
        cur_floor = 2'd2; at_floor = 1'b0; tick();
        chk("f_skip", int'(dir_up), 1);
        cur_floor = 2'd3; at_floor = 1'b1; tick();
        chk("f_top_up_off", int'(dir_up), 0);
        chk("f_top_down", int'(dir_down), 1);
        goto_floor(2'd2);
        chk("f_door2", int'(door_open), 1);
        chk("f_pend2", int'(pending), 0);
        door_len("f_len2", 5);

        // Reset restores up-preference
        rst = 1'b1; tick(); rst = 1'b0;
        cur_floor = 2'd1;
        req = 4'b1001; tick(); req = '0; tick();
        chk("g_pref_up", int'(dir_up), 1);
        chk("g_pref_not_down", int'(dir_down), 0);
        goto_floor(2'd2);
        goto_floor(2'd3);
        chk("g_pend3", int'(pending), 'h1);
        door_len("g_len3", 5);
        chk("g_down", int'(dir_down), 1);
        goto_floor(2'd2);
        goto_floor(2'd1);
        goto_floor(2'd0);
        door_len("g_len0", 5);

        // Asynchronous reset in the middle of an upward move
        req = 4'b1000; tick(); req = '0; tick();
        req = 4'b0010; tick(); req = '0;
        chk("h_up", int'(dir_up), 1);
        chk("h_pend", int'(pending), 'ha);
        #3;
        rst = 1'b1;
        #1;
        chk("h_async_up", int'(dir_up), 0);
        chk("h_async_pend", int'(pending), 0);
        chk("h_async_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("h_resume_busy", int'(busy), 0);
        chk("h_resume_pend", int'(pending), 0);
        tick();
        chk("h_resume_up", int'(dir_up), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
